// File: rtl/mist_spi_host.sv
// mist_spi_host: SPI mode-0 initiator for the user_io configuration link.
// Defining SPI_HOST_ABORT_EN adds abort_i, which cuts a transfer short without done_o.
module mist_spi_host #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [7:0]  cmd_i,
  input  logic [2:0]  tx_len_i,
  input  logic [31:0] tx_data_i,
  input  logic [7:0]  rx_len_i,
`ifdef SPI_HOST_ABORT_EN
  input  logic        abort_i,
`endif
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  rx_byte_o,
  output logic        rx_valid_o,
  output logic        spi_sck_o,
  output logic        spi_ss_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BYTE_W = 9;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_TAIL  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              sck_q, sck_d;
  logic              ss_n_q, ss_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_pend_q, rx_pend_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]        tx_sr_q, tx_sr_d;
  logic [7:0]        rx_sr_q, rx_sr_d;
  logic [2:0]        tx_len_q, tx_len_d;
  logic [31:0]       tx_data_q, tx_data_d;
  logic [7:0]        rx_len_q, rx_len_d;

  logic [BYTE_W-1:0] byte_nxt_c;
  logic [1:0]        shamt_c;
  logic [7:0]        next_byte_c;
  logic              last_byte_c;
  logic              read_byte_c;
  logic              div_zero_c;

  // Byte loaded after the current one: payload high byte first, then 0x00 for reads.
  assign byte_nxt_c  = byte_cnt_q + BYTE_W'(1);
  assign shamt_c     = 2'(tx_len_q - byte_nxt_c[2:0]);
  assign next_byte_c = (byte_nxt_c <= BYTE_W'(tx_len_q)) ? 8'(tx_data_q >> {shamt_c, 3'b000}) : 8'h00;
  assign last_byte_c = (byte_cnt_q == BYTE_W'(tx_len_q) + BYTE_W'(rx_len_q));
  assign read_byte_c = (byte_cnt_q > BYTE_W'(tx_len_q));
  assign div_zero_c  = (div_q == '0);

  always_comb begin
    state_d    = state_q;
    div_d      = div_zero_c ? div_q : div_q - DIV_W'(1);
    sck_d      = sck_q;
    ss_n_d     = ss_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rx_pend_d  = 1'b0;
    rx_valid_d = rx_pend_q;
    rx_byte_d  = rx_pend_q ? rx_sr_q : rx_byte_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    tx_len_d   = tx_len_q;
    tx_data_d  = tx_data_q;
    rx_len_d   = rx_len_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_SETUP;
          div_d      = DIV_RELOAD;
          ss_n_d     = 1'b0;
          sck_d      = 1'b0;
          busy_d     = 1'b1;
          tx_sr_d    = cmd_i;
          tx_len_d   = (tx_len_i > 3'd4) ? 3'd4 : tx_len_i;
          tx_data_d  = tx_data_i;
          rx_len_d   = rx_len_i;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end
      S_SETUP: begin
        if (div_zero_c) begin
          state_d = S_SHIFT;
          div_d   = DIV_RELOAD;
        end
      end
      S_SHIFT: begin
        if (div_zero_c) begin
          div_d = DIV_RELOAD;
          if (!sck_q) begin
            // Rising edge: sample MISO on the same clk_sys edge that raises SCK.
            sck_d     = 1'b1;
            rx_sr_d   = {rx_sr_q[6:0], spi_miso_i};
            rx_pend_d = (bit_cnt_q == 3'd7) && read_byte_c;
          end else begin
            sck_d     = 1'b0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q != 3'd7) begin
              tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end else if (last_byte_c) begin
              state_d = S_TAIL;
              tx_sr_d = '0;
            end else begin
              byte_cnt_d = byte_nxt_c;
              tx_sr_d    = next_byte_c;
            end
          end
        end
      end
      S_TAIL: begin
        if (div_zero_c) begin
          state_d = S_GAP;
          div_d   = DIV_RELOAD;
          ss_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (div_zero_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SPI_HOST_ABORT_EN
    // Abort drops the link to idle levels and lets GAP run out; no done, no partial byte.
    if (abort_i && busy_q) begin
      state_d   = S_GAP;
      div_d     = DIV_RELOAD;
      sck_d     = 1'b0;
      ss_n_d    = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      rx_pend_d = 1'b0;
      tx_sr_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      sck_q      <= 1'b0;
      ss_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_pend_q  <= 1'b0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      tx_len_q   <= '0;
      tx_data_q  <= '0;
      rx_len_q   <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sck_q      <= sck_d;
      ss_n_q     <= ss_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_pend_q  <= rx_pend_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      tx_len_q   <= tx_len_d;
      tx_data_q  <= tx_data_d;
      rx_len_q   <= rx_len_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rx_byte_o  = rx_byte_q;
  assign rx_valid_o = rx_valid_q;
  assign spi_sck_o  = sck_q;
  assign spi_ss_n_o = ss_n_q;
  assign spi_mosi_o = tx_sr_q[7];

endmodule

// File: tb/tb_mist_spi_host.sv
// Bench for mist_spi_host: a CLK_DIV=2 and a CLK_DIV=1 instance share one stimulus bus;
// a byte-level SPI slave model supplies MISO and predicts MOSI bytes, rx bytes and latency.
module tb_mist_spi_host;
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset_n, start2, start1, miso, sel;
  logic [7:0]  cmd, rx_len;
  logic [2:0]  tx_len;
  logic [31:0] tx_data;
  logic        busy2, done2, rxv2, sck2, ss2, mosi2;
  logic        busy1, done1, rxv1, sck1, ss1, mosi1;
  logic [7:0]  rxb2, rxb1;
`ifdef SPI_HOST_ABORT_EN
  logic        abort2, abort1;
`endif

  logic       busy, done, rxv, sck, ss_n, mosi;
  logic [7:0] rxb;
  assign busy = sel ? busy1 : busy2;
  assign done = sel ? done1 : done2;
  assign rxv  = sel ? rxv1  : rxv2;
  assign sck  = sel ? sck1  : sck2;
  assign ss_n = sel ? ss1   : ss2;
  assign mosi = sel ? mosi1 : mosi2;
  assign rxb  = sel ? rxb1  : rxb2;

  int checks = 0;
  int failures = 0;

  mist_spi_host #(.CLK_DIV(2)) u_dut2 (
    .clk_sys(clk_sys), .reset_n(reset_n), .start_i(start2), .cmd_i(cmd),
    .tx_len_i(tx_len), .tx_data_i(tx_data), .rx_len_i(rx_len),
`ifdef SPI_HOST_ABORT_EN
    .abort_i(abort2),
`endif
    .busy_o(busy2), .done_o(done2), .rx_byte_o(rxb2), .rx_valid_o(rxv2),
    .spi_sck_o(sck2), .spi_ss_n_o(ss2), .spi_mosi_o(mosi2), .spi_miso_i(miso)
  );

  mist_spi_host #(.CLK_DIV(1)) u_dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .start_i(start1), .cmd_i(cmd),
    .tx_len_i(tx_len), .tx_data_i(tx_data), .rx_len_i(rx_len),
`ifdef SPI_HOST_ABORT_EN
    .abort_i(abort1),
`endif
    .busy_o(busy1), .done_o(done1), .rx_byte_o(rxb1), .rx_valid_o(rxv1),
    .spi_sck_o(sck1), .spi_ss_n_o(ss1), .spi_mosi_o(mosi1), .spi_miso_i(miso)
  );

  // One full transaction on instance s (0: CLK_DIV=2, 1: CLK_DIV=1) against the model.
  task automatic do_txn(input string name, input bit s, input logic [7:0] c, input logic [2:0] tl,
                        input logic [31:0] d, input logic [7:0] rl, input bit pulse_start,
                        input bit use_pat, input logic [23:0] pat);
    int div, tle, n, lat, rise_cnt, last_rise_k, done_k, rx_cnt, rx_bad, tim_bad, stable, bidx, tx_bad, first_bad;
    logic [7:0] exp_tx[260];
    logic [7:0] got_tx[260];
    logic [7:0] reply[260];
    logic [7:0] rb;
    logic prev_sck, prev_mosi, end_ok;
    div = s ? 1 : 2;
    tle = (tl > 3'd4) ? 4 : int'(tl);
    n   = 1 + tle + int'(rl);
    lat = div * (2 + 16 * n);
    for (int i = 0; i < 260; i++) begin
      exp_tx[i] = 8'h00;
      got_tx[i] = 8'h00;
      reply[i]  = 8'($urandom);
    end
    exp_tx[0] = c;
    for (int j = 0; j < tle; j++) exp_tx[1+j] = 8'(d >> (8 * (tle - 1 - j)));
    if (use_pat) for (int i = 0; i < 3; i++) reply[1+tle+i] = 8'(pat >> (8 * (2 - i)));

    @(negedge clk_sys);
    sel = s; cmd = c; tx_len = tl; tx_data = d; rx_len = rl;
    if (s) start1 = 1'b1; else start2 = 1'b1;
    rb = reply[0];
    miso = rb[7];
    rise_cnt = 0; last_rise_k = -10; done_k = -1; rx_cnt = 0; rx_bad = 0; tim_bad = 0;
    stable = 0; prev_sck = 1'b0; prev_mosi = 1'b0; end_ok = 1'b0; tx_bad = 0; first_bad = -1;
    for (int k = 0; k <= lat + 20; k++) begin
      @(negedge clk_sys);
      if (k == 0) begin
        start1 = 1'b0; start2 = 1'b0;
        cmd = 8'($urandom); tx_len = 3'($urandom); tx_data = $urandom; rx_len = 8'($urandom);
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy_rise: busy=%b required 1", name, busy);
        end
      end else if (pulse_start && k < lat - 1) begin
        if (s) start1 = 1'($urandom); else start2 = 1'($urandom);
      end else begin
        start1 = 1'b0; start2 = 1'b0;
      end
      if (mosi !== prev_mosi) begin
        if (sck === 1'b1) tim_bad++;
        stable = 0;
      end else begin
        stable++;
      end
      if (rxv === 1'b1) begin
        bidx = rise_cnt / 8 - 1;
        if (last_rise_k != k - 1 || rise_cnt % 8 != 0 || bidx < 1 + tle || rx_cnt >= int'(rl) ||
            rxb !== reply[bidx]) rx_bad++;
        rx_cnt++;
      end
      if (sck === 1'b1 && prev_sck === 1'b0) begin
        if (stable < div) tim_bad++;
        if (rise_cnt < 8 * n) begin
          bidx = rise_cnt / 8;
          got_tx[bidx] = {got_tx[bidx][6:0], mosi};
        end
        rise_cnt++;
        last_rise_k = k;
      end
      prev_sck = sck;
      prev_mosi = mosi;
      if (done === 1'b1) begin
        done_k = k;
        end_ok = (busy === 1'b0) && (ss_n === 1'b1) && (sck === 1'b0);
        break;
      end
      if (rise_cnt < 8 * n) begin
        rb = reply[rise_cnt / 8];
        miso = rb[7 - rise_cnt % 8];
      end
    end
    start1 = 1'b0; start2 = 1'b0;

    checks++;
    if (done_k != lat) begin
      failures++;
      $display("FAIL %s latency: done after %0d cycles, required %0d", name, done_k, lat);
    end
    checks++;
    if (rise_cnt != 8 * n) begin
      failures++;
      $display("FAIL %s sck_edges: %0d rising edges, required %0d", name, rise_cnt, 8 * n);
    end
    for (int i = 0; i < n; i++) begin
      if (got_tx[i] !== exp_tx[i]) begin
        tx_bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (tx_bad != 0) begin
      failures++;
      $display("FAIL %s mosi_bytes: byte %0d got 0x%02h required 0x%02h (%0d bad)", name, first_bad,
               got_tx[first_bad], exp_tx[first_bad], tx_bad);
    end
    checks++;
    if (rx_cnt != int'(rl) || rx_bad != 0) begin
      failures++;
      $display("FAIL %s rx_bytes: %0d pulses (%0d wrong), required %0d correct", name, rx_cnt, rx_bad, rl);
    end
    checks++;
    if (tim_bad != 0) begin
      failures++;
      $display("FAIL %s mosi_timing: %0d violations, required 0", name, tim_bad);
    end
    checks++;
    if (!end_ok) begin
      failures++;
      $display("FAIL %s end_levels: busy=%b ss_n=%b sck=%b at done, required 0 1 0", name, busy, ss_n, sck);
    end
    @(negedge clk_sys);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse: done=%b one cycle later, required 0", name, done);
    end
    repeat (div + 2) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    int bad;
    sel = 1'b0; reset_n = 1'b0; start1 = 1'b0; start2 = 1'b0; miso = 1'b0;
    cmd = 8'h00; tx_len = 3'd0; tx_data = 32'h0; rx_len = 8'h00;
`ifdef SPI_HOST_ABORT_EN
    abort1 = 1'b0; abort2 = 1'b0;
`endif
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      checks++;
      if ({sck, ss_n, mosi, busy, done, rxv} !== 6'b010000) begin
        failures++;
        $display("FAIL reset_levels[%0d]: sck,ss_n,mosi,busy,done,rxv=%b required 010000", s,
                 {sck, ss_n, mosi, busy, done, rxv});
      end
      checks++;
      if (rxb !== 8'h00) begin
        failures++;
        $display("FAIL reset_rx_byte[%0d]: 0x%02h required 0x00", s, rxb);
      end
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk_sys);
      if ({sck2, ss2, mosi2, busy2, done2, rxv2, rxb2} !== 14'b01_0000_0000_0000) bad++;
      if ({sck1, ss1, mosi1, busy1, done1, rxv1, rxb1} !== 14'b01_0000_0000_0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_hold: %0d cycles with outputs off idle levels, required 0", bad);
    end
  endtask

  task automatic test_status8();
    do_txn("status8", 1'b0, 8'h15, 3'd1, 32'h0000_00A5, 8'd0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic test_status32();
    do_txn("status32", 1'b0, 8'h1E, 3'd4, 32'h1234_5678, 8'd0, 1'b0, 1'b0, 24'h0);
    do_txn("status32_clamp", 1'b0, 8'h1E, 3'd7, 32'h1234_5678, 8'd0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic test_conf_read();
    do_txn("conf_read", 1'b1, 8'h14, 3'd0, $urandom, 8'd3, 1'b0, 1'b1, 24'h506F6E);
  endtask

  task automatic test_boundaries();
    do_txn("opcode_only_div2", 1'b0, 8'h1A, 3'd0, $urandom, 8'd0, 1'b0, 1'b0, 24'h0);
    do_txn("opcode_only_div1", 1'b1, 8'hC3, 3'd0, $urandom, 8'd0, 1'b0, 1'b0, 24'h0);
    do_txn("max_read", 1'b1, 8'h14, 3'd4, $urandom, 8'd255, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic test_back_to_back();
    int rise_k, fall2_k, done1_k, done2_k;
    logic prev_ss;
    @(negedge clk_sys);
    sel = 1'b0; cmd = 8'h15; tx_len = 3'd1; tx_data = 32'h0000_005A; rx_len = 8'd0;
    start2 = 1'b1;
    prev_ss = 1'b1; rise_k = -1; fall2_k = -1; done1_k = -1; done2_k = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_sys);
      if (ss_n === 1'b0 && prev_ss === 1'b1 && done1_k >= 0 && fall2_k < 0) fall2_k = k;
      if (ss_n === 1'b1 && prev_ss === 1'b0 && rise_k < 0) rise_k = k;
      if (done === 1'b1) begin
        if (done1_k < 0) done1_k = k;
        else begin
          done2_k = k;
          break;
        end
      end
      prev_ss = ss_n;
    end
    start2 = 1'b0;
    checks++;
    if (done1_k != 68) begin
      failures++;
      $display("FAIL b2b_first_done: %0d cycles, required 68", done1_k);
    end
    checks++;
    if (rise_k < 0 || fall2_k < 0 || fall2_k - rise_k < 2) begin
      failures++;
      $display("FAIL b2b_gap: ss_n high %0d cycles (rise %0d fall %0d), required >= 2", fall2_k - rise_k,
               rise_k, fall2_k);
    end
    checks++;
    if (done2_k < 0 || done2_k - fall2_k != 68) begin
      failures++;
      $display("FAIL b2b_second_done: %0d cycles after select, required 68", done2_k - fall2_k);
    end
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      do_txn("random", 1'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), $urandom,
             8'($urandom_range(0, 4)), 1'($urandom), 1'b0, 24'h0);
    end
  endtask

  // Run instance 0 into byte 2 (19 rising edges) and return; reached flag reports success.
  task automatic run_to_byte2(output bit reached);
    int rises;
    logic prev;
    @(negedge clk_sys);
    sel = 1'b0; cmd = 8'h14; tx_len = 3'd0; tx_data = $urandom; rx_len = 8'd3;
    start2 = 1'b1;
    @(negedge clk_sys);
    start2 = 1'b0;
    rises = 0; prev = sck; reached = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_sys);
      if (sck === 1'b1 && prev === 1'b0) rises++;
      prev = sck;
      if (rises >= 19) begin
        reached = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit reached;
    int dn;
    run_to_byte2(reached);
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL reset_mid_reach: byte 2 not reached, required reached");
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ss2, sck2, busy2, done2, mosi2} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_mid_levels: ss_n,sck,busy,done,mosi=%b required 10000", {ss2, sck2, busy2, done2, mosi2});
    end
    dn = 0;
    repeat (3) begin
      @(negedge clk_sys);
      if (done2 !== 1'b0) dn++;
    end
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk_sys);
      if (done2 !== 1'b0 || busy2 !== 1'b0) dn++;
    end
    checks++;
    if (dn != 0) begin
      failures++;
      $display("FAIL reset_mid_nodone: %0d cycles with done/busy set, required 0", dn);
    end
    do_txn("after_reset", 1'b0, 8'h15, 3'd1, 32'h0000_00C6, 8'd1, 1'b0, 1'b0, 24'h0);
  endtask

`ifdef SPI_HOST_ABORT_EN
  task automatic test_abort();
    bit reached;
    int bad;
    run_to_byte2(reached);
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL abort_reach: byte 2 not reached, required reached");
    end
    abort2 = 1'b1;
    @(negedge clk_sys);
    abort2 = 1'b0;
    checks++;
    if ({ss2, sck2, busy2, done2} !== 4'b1000) begin
      failures++;
      $display("FAIL abort_levels: ss_n,sck,busy,done=%b required 1000", {ss2, sck2, busy2, done2});
    end
    bad = 0;
    repeat (8) begin
      @(negedge clk_sys);
      if (done2 !== 1'b0 || rxv2 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_quiet: %0d cycles with done/rx_valid, required 0", bad);
    end
    do_txn("after_abort", 1'b0, 8'h1A, 3'd2, 32'h0000_BEEF, 8'd1, 1'b0, 1'b0, 24'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_status8();
    test_status32();
    test_conf_read();
    test_boundaries();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef SPI_HOST_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mist_spi_host.md
Name: mist_spi_host

Overview:
- SPI initiator that drives the IO-controller side of the user_io configuration link: SPI_SCK, SPI_DI, and the CONF_DATA0 select, with SPI_DO sampled back.
- Lets the core's bench, and any on-FPGA host replacement, push status words and analog-joystick values into user_io, and read back the core's configuration string.
- Sits next to user_io in clk_sys domain and issues one command transaction per start.

Parameters:
- CLK_DIV, 4, clk_sys cycles per SCK half-period; legal range is 1 to 255, and 0 is illegal.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- start_i  in  1  request a transaction; sampled only in IDLE
- cmd_i  in  8  opcode byte, sent first (0x14 read conf string, 0x15 8-bit status, 0x1E 32-bit status, 0x1A analog joystick)
- tx_len_i  in  3  payload byte count, 0 to 4; values above 4 are treated as 4
- tx_data_i  in  32  payload, right-aligned; the byte tx_data_i[8*tx_len-1 -: 8] is sent first
- rx_len_i  in  8  number of read bytes after the payload, 0 to 255
- busy_o  out  1  transaction in progress
- done_o  out  1  one-cycle pulse at transaction end
- rx_byte_o  out  8  last byte received on MISO
- rx_valid_o  out  1  one-cycle pulse when rx_byte_o updates (read bytes only)
- spi_sck_o  out  1  SCK; idles low
- spi_ss_n_o  out  1  select, active low (drives CONF_DATA0)
- spi_mosi_o  out  1  MOSI, MSB first
- spi_miso_i  in  1  MISO

Behaviour:
- Reset values: sck=0, ss_n=1, mosi=0, busy=0, done=0, rx_valid=0, rx_byte=0x00, FSM=IDLE. Reset is honoured mid-transfer; the link returns to idle levels asynchronously.
- SPI mode 0:
  - MOSI changes only while SCK is low, at least CLK_DIV cycles before each rising edge.
  - MISO is sampled on the clk_sys edge that raises SCK.
- Start: accepted when FSM=IDLE and start_i=1.
  - cmd, tx_len (clamped), tx_data and rx_len are latched.
  - busy_o goes high the next cycle.
  - start_i is ignored while busy.
- N = 1 + tx_len + rx_len bytes per transaction. Read bytes transmit 0x00 on MOSI.
- States:
  - IDLE: waiting for an accepted start.
  - SETUP: ss_n=0, sck=0, first MOSI bit driven; lasts CLK_DIV cycles.
  - SHIFT: 8 bits per byte; each bit is CLK_DIV cycles with sck low, then CLK_DIV cycles with sck high. The byte counter advances after the 8th falling edge, so no idle gap exists between bytes.
  - TAIL: sck=0 for CLK_DIV cycles after the last falling edge.
  - GAP: ss_n=1 for CLK_DIV cycles; no start is accepted here. Then return to IDLE.
- done_o pulses on the first GAP cycle, and busy_o falls on that same cycle.
- Total latency from start acceptance to done_o is CLK_DIV*(2+16N) cycles.
- Read bytes:
  - rx_byte_o and rx_valid_o update one cycle after the 8th rising edge of each read byte.
  - Opcode and payload bytes never pulse rx_valid.
- rx_len=0 and tx_len=0 together give a 1-byte (opcode-only) transaction.
- Bit counter is 3 bits wrapping 7→0; byte counter is 9 bits. There is no overflow case, since N ≤ 260.

Optional Feature:
- SPI_HOST_ABORT_EN defined:
  - Adds input abort_i (1 bit).
  - abort_i=1 while busy forces sck=0 and ss_n=1 on the next cycle and enters GAP.
  - done_o is not pulsed, and a partially received byte does not raise rx_valid.
  - abort_i in IDLE or GAP has no effect.
- Undefined: no abort_i port; a transaction can only end by completion or reset.

Test Plan:
- Reset/idle: assert reset_n=0 → sck=0, ss_n=1, mosi=0, busy=0, done=0. Release and hold 100 cycles with start_i=0 → all outputs unchanged.
- 8-bit status, CLK_DIV=2: cmd=0x15, tx_len=1, tx_data=0x000000A5, rx_len=0 → 16 SCK rising edges, MOSI samples 0x15 then 0xA5, done_o exactly 68 cycles after acceptance, no rx_valid.
- 32-bit status, CLK_DIV=2: cmd=0x1E, tx_len=4, tx_data=0x12345678 → bytes 0x1E,0x12,0x34,0x56,0x78 observed, done at 164 cycles. Repeat with tx_len=7 → identical bytes and timing (clamp).
- Conf read, CLK_DIV=1: cmd=0x14, tx_len=0, rx_len=3, slave model returns 0x50,0x6F,0x6E → exactly 3 rx_valid pulses carrying those values in order, MOSI=0x00 during read bytes, done at 66 cycles.
- Handshake: hold start_i=1 continuously → second transaction's ss_n falls no earlier than CLK_DIV cycles after the first's ss_n rose. start_i pulses mid-transfer are ignored; rx/tx byte counts are unaffected.
- Reset mid-transfer during byte 2: reset_n=0 → ss_n=1, sck=0, busy=0 immediately, no done_o. With SPI_HOST_ABORT_EN, abort_i during byte 2 → ss_n=1 next cycle, no done_o, no rx_valid, next start accepted after GAP.
